client_req_queue: RTL and testbench
===================================

# client_req_queue

Command-queueing front end placed directly upstream of a `client` memory-access block. It accepts read and write commands from a producer over a valid/ready port and buffers them in a DEPTH-entry FIFO. It issues them one at a time on the client's `req_in`/`wr_in`/`addr_in`/`data_in` handshake, waiting for `done` on each. It returns one response per command (read data, or a write acknowledgement) on a valid/ready response port.

## Interface
Parameters:
- `DEPTH`, 4, command FIFO entries; power of two, ≥2
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted)
- `cmd_valid`  in  1  producer command valid
- `cmd_ready`  out  1  FIFO can accept a command
- `cmd_wr`  in  1  1 = write, 0 = read
- `cmd_addr`  in  ADDR_W  command address
- `cmd_wdata`  in  DATA_W  write data; ignored for reads
- `cl_req`  out  1  to client `req_in`
- `cl_wr`  out  1  to client `wr_in`
- `cl_addr`  out  ADDR_W  to client `addr_in`
- `cl_wdata`  out  DATA_W  to client `data_in`
- `cl_done`  in  1  from client `done`
- `cl_rdata`  in  DATA_W  from client `data_out`
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  consumer accepts the response
- `rsp_wr`  out  1  response belongs to a write
- `rsp_addr`  out  ADDR_W  address of the completed command
- `rsp_rdata`  out  DATA_W  read data; 0 for writes
- `count`  out  $clog2(DEPTH+1)  FIFO occupancy
- `busy`  out  1  FIFO non-empty or FSM not in IDLE

## Operation
- **Command FIFO:**
  - Push on `cmd_valid && cmd_ready`.
  - `cmd_ready = (count != DEPTH)`.
  - Read and write pointers are log2(DEPTH) bits and wrap naturally.
  - Push and pop in the same cycle leave `count` unchanged. A push when full is impossible because `cmd_ready` is low.
- **FSM states:** IDLE, REQ, RSP.
  - **IDLE:** if FIFO non-empty, pop the head into the issue registers (`cl_wr`, `cl_addr`, `cl_wdata`), set `cl_req=1`, and go to REQ. If the FIFO is empty, stay in IDLE.
  - **REQ:** hold `cl_req=1` and the issue registers stable. When `cl_done` is sampled 1:
    - clear `cl_req`;
    - capture `rsp_rdata = cl_wr ? 0 : cl_rdata`, and set `rsp_wr = cl_wr`, `rsp_addr = cl_addr`;
    - set `rsp_valid=1` and go to RSP.
  - **RSP:** hold the response stable until `rsp_valid && rsp_ready`, then clear `rsp_valid` and go to IDLE.
- `cl_done` is ignored in IDLE and RSP.
- Only one command is outstanding at the client at any time. Responses are returned in command order.
- `busy = (count != 0) || (state != IDLE)`.

## Timing
- **Reset values:**
  - `cl_req`, `cl_wr`, `rsp_valid`, `rsp_wr`, `busy`: 0.
  - `cl_addr`, `cl_wdata`, `rsp_addr`, `rsp_rdata`: 0.
  - `count`: 0, and `cmd_ready`: 1 once reset deasserts.
  - FSM in IDLE; FIFO empty.
- **Reset mid-operation:** all state clears immediately. The queued commands and the in-flight client transaction are discarded, with no response. The client shares the same reset.
- **Command to request latency:** a command pushed at edge N into an empty FIFO, with the FSM in IDLE, raises `cl_req` after edge N+1.
- **Done to response latency:** `cl_done` sampled at edge M gives `cl_req=0` and `rsp_valid=1` after edge M.
- **Minimum request gap:** with the response accepted at edge K, the next `cl_req` rises no earlier than after edge K+1. `cl_req` is therefore low for ≥2 cycles between transactions, which satisfies the client's need to see a fresh rising edge.
- **Throughput:** at best one command every 3 cycles plus client latency.
- **`count`:** registered; it updates on the edge of push/pop.

## Structure
- **Package `client_q_pkg`:**
  - FSM state enum (IDLE/REQ/RSP);
  - default `ADDR_W`/`DATA_W`;
  - the command struct {wr, addr, wdata}.
- **Sub-module `sync_fifo`:**
  - parameterised width/depth;
  - push/pop/full/empty/count;
  - active-low async reset.

  It stores the packed command struct. The FSM and response register live in the top module.

## Test plan
- **Write then read:**
  - Stimulus: write addr 0x05 data 0xDEADBEEF, then read addr 0x05, with the real client, server and Memory behind the block.
  - Required: two responses in order, `rsp_wr=1`/`rsp_rdata=0`, then `rsp_wr=0`/`rsp_rdata=0xDEADBEEF`.
- **Fill and overflow:**
  - Stimulus: stall the client (never assert `cl_done`) and push commands.
  - Required: the first pops; 4 more fill the FIFO; `count=4`, `cmd_ready=0`. The 6th command is held, not lost, and is accepted after the next pop.
- **Response backpressure:**
  - Stimulus: `rsp_ready=0` for 10 cycles after `rsp_valid`.
  - Required: the response is held stable, `cl_req` stays 0, and no pop occurs. With `rsp_ready=1`, IDLE follows, then `cl_req` rises the next cycle.
- **Simultaneous push/pop:**
  - Stimulus: FIFO at count 2, push and pop on the same edge.
  - Required: count stays 2. The order of the 8 responses matches the issued addresses 0..7 across pointer wrap.
- **Spurious done:**
  - Stimulus: pulse `cl_done` in IDLE and in RSP.
  - Required: no state change and no extra response.
- **Reset in REQ:**
  - Stimulus: assert `reset=0` mid-cycle while `cl_req=1` with 3 commands queued.
  - Required: `cl_req`, `rsp_valid` and `count` go to 0 immediately (asynchronously). After release, no response is ever produced for the discarded commands.

Source files
------------

// File: rtl/client_req_queue_pkg.sv
// ----------------------------------------------------------------------------
// client_q_pkg
// Shared types for the client command queue:
//   - state_e  : issue FSM states (IDLE / REQ / RSP)
//   - cmd_t    : command record {wr, addr, wdata} at the default widths
//   - cmd_bits : packed width of a command record for arbitrary widths
// ----------------------------------------------------------------------------
package client_q_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  typedef struct packed {
    logic                  wr;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } cmd_t;

  function automatic int cmd_bits(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction

endpackage

// File: rtl/client_req_queue_if.sv
// ----------------------------------------------------------------------------
// client_req_queue_if
// Bundles the three handshakes around the queue:
//   cmd_* : producer -> queue command port (valid/ready)
//   cl_*  : queue <-> client memory-access block (req/done)
//   rsp_* : queue -> consumer response port (valid/ready)
// Modports:
//   slave  : the queue's view (drives cmd_ready, cl_*, rsp_* outputs)
//   master : the environment's view (producer, client and consumer side)
// ----------------------------------------------------------------------------
interface client_req_queue_if
  import client_q_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              cl_req;
  logic              cl_wr;
  logic [ADDR_W-1:0] cl_addr;
  logic [DATA_W-1:0] cl_wdata;
  logic              cl_done;
  logic [DATA_W-1:0] cl_rdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_wr;
  logic [ADDR_W-1:0] rsp_addr;
  logic [DATA_W-1:0] rsp_rdata;

  modport slave (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
    output cmd_ready,
    output cl_req, cl_wr, cl_addr, cl_wdata,
    input  cl_done, cl_rdata,
    output rsp_valid, rsp_wr, rsp_addr, rsp_rdata,
    input  rsp_ready
  );

  modport master (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  cl_req, cl_wr, cl_addr, cl_wdata,
    output cl_done, cl_rdata,
    input  rsp_valid, rsp_wr, rsp_addr, rsp_rdata,
    output rsp_ready
  );

endinterface

// File: rtl/client_req_queue_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO (head word visible on rdata_o while not empty).
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   push_i, wdata_i : write strobe and data (ignored when full)
//   pop_i           : remove head word (ignored when empty)
//   rdata_o         : current head word
//   full_o, empty_o : occupancy flags
//   count_o         : registered occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap without extra logic.
// ----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d  = do_push ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d  = do_pop  ? rptr_q + PTR_W'(1) : rptr_q;
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; stale words are never visible because the
  // pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/client_req_queue.sv
// ----------------------------------------------------------------------------
// client_req_queue
// Buffers read/write commands in a DEPTH-entry FIFO and issues them one at a
// time to a downstream client block, returning one in-order response each.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset (clears queue and in-flight work)
//   bus    : client_req_queue_if.slave (cmd_*, cl_*, rsp_* handshakes)
//   count  : FIFO occupancy
//   busy   : FIFO non-empty or a command still in flight
// ----------------------------------------------------------------------------
module client_req_queue
  import client_q_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                         clk,
  input  logic                         reset,
  client_req_queue_if.slave            bus,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         busy
);

  localparam int CMD_W = cmd_bits(ADDR_W, DATA_W);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } qcmd_t;

  qcmd_t             push_cmd;
  qcmd_t             head_cmd;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              pop;

  state_e            state_q;
  logic              cl_req_q;
  logic              cl_wr_q;
  logic [ADDR_W-1:0] cl_addr_q;
  logic [DATA_W-1:0] cl_wdata_q;
  logic              rsp_valid_q;
  logic              rsp_wr_q;
  logic [ADDR_W-1:0] rsp_addr_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  assign push_cmd = '{wr: bus.cmd_wr, addr: bus.cmd_addr, wdata: bus.cmd_wdata};

  // Pop only when the FSM is free to take the head into the issue registers.
  assign pop = (state_q == ST_IDLE) && !fifo_empty;

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (bus.cmd_valid && bus.cmd_ready),
    .wdata_i (push_cmd),
    .pop_i   (pop),
    .rdata_o (head_cmd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Issue / response FSM. cl_done is only honoured in REQ, so a stray pulse
  // while idle or while a response is pending has no effect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cl_req_q    <= 1'b0;
      cl_wr_q     <= 1'b0;
      cl_addr_q   <= '0;
      cl_wdata_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_wr_q    <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            cl_req_q   <= 1'b1;
            cl_wr_q    <= head_cmd.wr;
            cl_addr_q  <= head_cmd.addr;
            cl_wdata_q <= head_cmd.wdata;
            state_q    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.cl_done) begin
            cl_req_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_wr_q    <= cl_wr_q;
            rsp_addr_q  <= cl_addr_q;
            rsp_rdata_q <= cl_wr_q ? '0 : bus.cl_rdata;
            state_q     <= ST_RSP;
          end
        end
        ST_RSP: begin
          // Returning through IDLE guarantees cl_req stays low for at least
          // two cycles, giving the client a clean rising edge per command.
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = !fifo_full;
  assign bus.cl_req    = cl_req_q;
  assign bus.cl_wr     = cl_wr_q;
  assign bus.cl_addr   = cl_addr_q;
  assign bus.cl_wdata  = cl_wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_wr    = rsp_wr_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  assign count = fifo_count;
  assign busy  = (fifo_count != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_client_req_queue.sv
// ----------------------------------------------------------------------------
// tb_client_req_queue
// Directed bench for client_req_queue. A behavioural client with a small
// memory answers cl_req after a programmable latency (or stalls); expected
// responses are queued when each command is accepted and a monitor compares
// them as the DUT hands responses over.
// ----------------------------------------------------------------------------
module tb_client_req_queue;
  import client_q_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          reset;
  logic [CW-1:0] count;
  logic          busy;

  client_req_queue_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  client_req_queue #(
    .DEPTH  (DEPTH),
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .count (count),
    .busy  (busy)
  );

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] rdata;
  } rsp_t;

  rsp_t        sb[$];
  int          n_tests;
  int          n_fail;
  logic [31:0] mem [256];
  bit          stall;
  bit          spur_done;
  int          lat;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Caller must be just after a rising edge. Returns just after the
  // accepting edge. track=0 for commands that are expected to be discarded.
  task automatic send_cmd(input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] exp_rd,
                          input bit track);
    bit ok;
    ok = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    bus.cmd_valid = 1'b0;
    if (ok && track) sb.push_back('{wr, a, exp_rd});
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL cmd_accept timeout addr=0x%0h", a);
    end
  endtask

  task automatic wait_rsp_valid(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1);
  endtask

  task automatic drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy && !bus.rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1);
    @(posedge clk);
    #1;
  endtask

  // Behavioural client: one done pulse per rising cl_req after lat cycles.
  initial begin
    int cnt;
    bit served;
    bit dn;
    cnt          = 0;
    served       = 1'b0;
    bus.cl_done  = 1'b0;
    bus.cl_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      dn = 1'b0;
      if (!reset || !bus.cl_req) begin
        served = 1'b0;
        cnt    = 0;
      end else if (!served && !stall) begin
        cnt++;
        if (cnt >= lat) begin
          dn     = 1'b1;
          served = 1'b1;
          if (bus.cl_wr) mem[bus.cl_addr[7:0]] = bus.cl_wdata;
          else           bus.cl_rdata = mem[bus.cl_addr[7:0]];
        end
      end
      bus.cl_done = dn | spur_done;
    end
  end

  // Response monitor: a handshake is visible at the falling edge before the
  // rising edge that completes it.
  initial begin
    rsp_t got;
    rsp_t exp;
    forever begin
      @(negedge clk);
      if (reset && bus.rsp_valid && bus.rsp_ready) begin
        got = '{bus.rsp_wr, bus.rsp_addr, bus.rsp_rdata};
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected: got wr=%0d addr=0x%0h rdata=0x%0h, want no response",
                   got.wr, got.addr, got.rdata);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            n_fail++;
            $display("FAIL rsp_order: got wr=%0d addr=0x%0h rdata=0x%0h, want wr=%0d addr=0x%0h rdata=0x%0h",
                     got.wr, got.addr, got.rdata, exp.wr, exp.addr, exp.rdata);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    reset         = 1'b1;
    stall         = 1'b0;
    spur_done     = 1'b0;
    lat           = 2;
    bus.cmd_valid = 1'b0;
    bus.cmd_wr    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    // Reset state
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cl_req",    bus.cl_req, 0);
    check("rst_cl_wr",     bus.cl_wr, 0);
    check("rst_cl_addr",   bus.cl_addr, 0);
    check("rst_cl_wdata",  bus.cl_wdata, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_wr",    bus.rsp_wr, 0);
    check("rst_rsp_addr",  bus.rsp_addr, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_count",     count, 0);
    check("rst_busy",      busy, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_busy_after", busy, 0);

    // Write then read, with command-to-request latency
    bus.rsp_ready = 1'b1;
    lat = 2;
    send_cmd(1'b1, 32'h5, 32'hDEADBEEF, 32'h0, 1'b1);
    check("lat_req_low_at_push", bus.cl_req, 0);
    check("lat_count_at_push",   count, 1);
    @(posedge clk);
    #1;
    check("lat_req_high", bus.cl_req, 1);
    check("lat_cl_wr",    bus.cl_wr, 1);
    check("lat_cl_addr",  bus.cl_addr, 32'h5);
    check("lat_cl_wdata", bus.cl_wdata, 32'hDEADBEEF);
    check("lat_count_pop", count, 0);
    send_cmd(1'b0, 32'h5, 32'h0, 32'hDEADBEEF, 1'b1);
    drain("wr_rd_drain");

    // Fill and overflow with a stalled client
    stall = 1'b1;
    send_cmd(1'b1, 32'h10, 32'hA0A0_0010, 32'h0, 1'b1);
    send_cmd(1'b1, 32'h11, 32'hA1A1_0011, 32'h0, 1'b1);
    send_cmd(1'b1, 32'h12, 32'hA2A2_0012, 32'h0, 1'b1);
    send_cmd(1'b0, 32'h10, 32'h0, 32'hA0A0_0010, 1'b1);
    send_cmd(1'b0, 32'h11, 32'h0, 32'hA1A1_0011, 1'b1);
    check("fill_count",     count, 4);
    check("fill_cmd_ready", bus.cmd_ready, 0);
    check("fill_cl_addr",   bus.cl_addr, 32'h10);
    fork
      send_cmd(1'b0, 32'h12, 32'h0, 32'hA2A2_0012, 1'b1);
      begin
        repeat (5) @(negedge clk);
        check("ovf_count_held", count, 4);
        check("ovf_ready_low",  bus.cmd_ready, 0);
        @(posedge clk);
        #1 stall = 1'b0;
      end
    join
    check("ovf_sixth_accepted", count, 4);
    drain("fill_drain");

    // Response backpressure
    bus.rsp_ready = 1'b0;
    lat = 1;
    send_cmd(1'b1, 32'h20, 32'h1234_5678, 32'h0, 1'b1);
    send_cmd(1'b0, 32'h20, 32'h0, 32'h1234_5678, 1'b1);
    wait_rsp_valid("bp_rsp_valid");
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_valid", bus.rsp_valid, 1);
      check("bp_hold_wr",    bus.rsp_wr, 1);
      check("bp_hold_addr",  bus.rsp_addr, 32'h20);
      check("bp_hold_rdata", bus.rsp_rdata, 0);
      check("bp_req_low",    bus.cl_req, 0);
      check("bp_no_pop",     count, 1);
      check("bp_busy",       busy, 1);
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_idle_req_low",   bus.cl_req, 0);
    check("bp_idle_valid_low", bus.rsp_valid, 0);
    @(posedge clk);
    #1;
    check("bp_next_req",  bus.cl_req, 1);
    check("bp_next_addr", bus.cl_addr, 32'h20);
    check("bp_next_wr",   bus.cl_wr, 0);
    drain("bp_drain");

    // Simultaneous push/pop at count 2, eight commands across pointer wrap
    bus.rsp_ready = 1'b0;
    send_cmd(1'b1, 32'h0, 32'h100, 32'h0, 1'b1);
    send_cmd(1'b0, 32'h1, 32'h0,   32'h0, 1'b1);
    send_cmd(1'b1, 32'h2, 32'h102, 32'h0, 1'b1);
    wait_rsp_valid("pp_rsp_valid");
    check("pp_count_before", count, 2);
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    send_cmd(1'b0, 32'h3, 32'h0, 32'h0, 1'b1);
    check("pp_count_same", count, 2);
    check("pp_req",        bus.cl_req, 1);
    check("pp_addr",       bus.cl_addr, 32'h1);
    send_cmd(1'b1, 32'h4, 32'h104, 32'h0, 1'b1);
    send_cmd(1'b0, 32'h5, 32'h0,   32'hDEADBEEF, 1'b1);
    send_cmd(1'b1, 32'h6, 32'h106, 32'h0, 1'b1);
    send_cmd(1'b0, 32'h7, 32'h0,   32'h0, 1'b1);
    drain("pp_drain");

    // Spurious done in IDLE
    @(posedge clk);
    #1 spur_done = 1'b1;
    @(posedge clk);
    #1 spur_done = 1'b0;
    @(posedge clk);
    #1;
    check("spur_idle_req",   bus.cl_req, 0);
    check("spur_idle_valid", bus.rsp_valid, 0);
    check("spur_idle_busy",  busy, 0);

    // Spurious done in RSP
    bus.rsp_ready = 1'b0;
    send_cmd(1'b0, 32'h11, 32'h0, 32'hA1A1_0011, 1'b1);
    wait_rsp_valid("spur_rsp_valid");
    @(posedge clk);
    #1 spur_done = 1'b1;
    @(posedge clk);
    #1 spur_done = 1'b0;
    @(posedge clk);
    #1;
    check("spur_rsp_hold",  bus.rsp_valid, 1);
    check("spur_rsp_addr",  bus.rsp_addr, 32'h11);
    check("spur_rsp_rdata", bus.rsp_rdata, 32'hA1A1_0011);
    check("spur_rsp_req",   bus.cl_req, 0);
    bus.rsp_ready = 1'b1;
    drain("spur_drain");

    // Reset while a command is in REQ and three more are queued
    stall = 1'b1;
    send_cmd(1'b1, 32'h30, 32'h3030, 32'h0, 1'b0);
    send_cmd(1'b1, 32'h31, 32'h3131, 32'h0, 1'b0);
    send_cmd(1'b0, 32'h30, 32'h0,    32'h0, 1'b0);
    send_cmd(1'b1, 32'h32, 32'h3232, 32'h0, 1'b0);
    check("rstreq_pre_req",   bus.cl_req, 1);
    check("rstreq_pre_count", count, 3);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rstreq_req",   bus.cl_req, 0);
    check("rstreq_valid", bus.rsp_valid, 0);
    check("rstreq_count", count, 0);
    check("rstreq_busy",  busy, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    stall = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("rstreq_after_req",  bus.cl_req, 0);
    check("rstreq_after_busy", busy, 0);
    check("rstreq_no_write",   mem[8'h30], 0);
    check("sb_empty_end",      sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
